// File: rtl/mux_arb_pkg.sv
// mux_arb_pkg: shared types and constants for the N-channel registered
// data selector (mux_arb) and its combinational winner picker.
// Optional build macro used by mux_arb: MUX_ARB_SVA_EN (embedded assertions).

package mux_arb_pkg;

    // Arbitration mode, driven directly from the rr_mode input bit.
    typedef enum logic {
        MODE_FIXED = 1'b0,
        MODE_RR    = 1'b1
    } mux_mode_e;

    // Reset value shared by rr_ptr and op_idx.
    localparam int unsigned IDX_RST = 0;

endpackage

// File: rtl/mux_arb_picker.sv
// mux_arb_picker: purely combinational winner selection.
// Fixed mode picks the lowest requesting index; round-robin mode scans
// upward from rr_ptr and wraps from N-1 back to 0.

module mux_arb_picker
    import mux_arb_pkg::*;
#(
    parameter int N    = 3,
    parameter int IDXW = 2
) (
    input  logic [N-1:0]    sel,
    input  logic [IDXW-1:0] rr_ptr,
    input  mux_mode_e       mode,
    output logic [IDXW-1:0] w,
    output logic            any_req
);

    logic found;

    // Scan requests from the mode-dependent start index; first hit wins.
    always_comb begin
        int base;
        int j;
        w       = '0;
        any_req = |sel;
        found   = 1'b0;
        base    = 0;
        j       = 0;
        if (mode == MODE_RR && int'(rr_ptr) < N) begin
            base = int'(rr_ptr);
        end
        for (int k = 0; k < N; k++) begin
            j = base + k;
            if (j >= N) begin
                j = j - N;
            end
            if (!found && sel[j]) begin
                w     = IDXW'(j);
                found = 1'b1;
            end
        end
    end

endmodule

// File: rtl/mux_arb.sv
// mux_arb: N-channel registered data selector with fixed-priority or
// round-robin arbitration and a valid/ready output handshake.
// A new value is loaded whenever the output register is empty or being
// consumed on the same edge, so back-to-back transfers run at full rate.
// Build macro: MUX_ARB_SVA_EN compiles in embedded assertions; behaviour
// is identical with or without it.

module mux_arb
    import mux_arb_pkg::*;
#(
    parameter int N = 3,
    parameter int W = 4
) (
    input  logic                              clock,
    input  logic                              reset,
    input  logic [N-1:0][W-1:0]               ip,
    input  logic [N-1:0]                      sel,
    input  logic                              rr_mode,
    input  logic                              out_ready,
    output logic [W-1:0]                      mux_op,
    output logic                              op_valid,
    output logic [((N > 1) ? $clog2(N) : 1)-1:0] op_idx
);

    localparam int IDXW = (N > 1) ? $clog2(N) : 1;

    mux_mode_e       mode;
    logic            accept;
    logic            any_req;
    logic [IDXW-1:0] w;
    logic [IDXW-1:0] rr_ptr;
    logic [IDXW-1:0] ptr_nxt;

    assign mode   = mux_mode_e'(rr_mode);
    assign accept = !op_valid || out_ready;

    // Pointer moves just past the winner, wrapping at the last channel.
    assign ptr_nxt = (w == IDXW'(N - 1)) ? '0 : (w + IDXW'(1));

    mux_arb_picker #(
        .N    (N),
        .IDXW (IDXW)
    ) u_picker (
        .sel     (sel),
        .rr_ptr  (rr_ptr),
        .mode    (mode),
        .w       (w),
        .any_req (any_req)
    );

    // Output register, handshake and round-robin pointer; all hold on stall.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            mux_op   <= '0;
            op_valid <= 1'b0;
            op_idx   <= IDXW'(IDX_RST);
            rr_ptr   <= IDXW'(IDX_RST);
        end else if (accept) begin
            if (any_req) begin
                mux_op   <= ip[w];
                op_idx   <= w;
                op_valid <= 1'b1;
                if (mode == MODE_RR) begin
                    rr_ptr <= ptr_nxt;
                end
            end else begin
                op_valid <= 1'b0;
            end
        end
    end

`ifdef MUX_ARB_SVA_EN
    logic [IDXW-1:0] low_idx;

    // Lowest requesting channel, found with a separate downward scan of sel.
    always_comb begin
        low_idx = '0;
        for (int i = N - 1; i >= 0; i--) begin
            if (sel[i]) begin
                low_idx = IDXW'(i);
            end
        end
    end

    a_fixed_prio: assert property (@(posedge clock) disable iff (reset)
        (accept && (|sel) && mode == MODE_FIXED) |=> (mux_op == $past(ip[low_idx])))
        else $error("mux_arb: fixed-priority winner data mismatch");

    a_latency: assert property (@(posedge clock) disable iff (reset)
        (accept && (|sel)) |=> (op_valid && op_idx == $past(w)))
        else $error("mux_arb: grant not registered one cycle later");

    a_stall_stable: assert property (@(posedge clock) disable iff (reset)
        (op_valid && !out_ready) |=> ($stable(mux_op) && $stable(op_idx) && $stable(op_valid)))
        else $error("mux_arb: outputs changed while stalled");

    a_idx_range: assert property (@(posedge clock) disable iff (reset)
        (int'(op_idx) < N))
        else $error("mux_arb: op_idx out of range");

    a_valid_fall: assert property (@(posedge clock) disable iff (reset)
        $fell(op_valid) |-> $past(accept && sel == '0))
        else $error("mux_arb: op_valid fell without an empty accept");
`else
    // Assertions not compiled in this build.
`endif

endmodule

// File: tb/tb_mux_arb.sv
// Testbench for mux_arb (N=3, W=4): directed table, reset corner case and
// randomized traffic checked against a behavioural reference model.

module tb_mux_arb;

    localparam int N = 3;
    localparam int W = 4;

    logic               clock;
    logic               reset;
    logic [N-1:0][W-1:0] ip;
    logic [N-1:0]       sel;
    logic               rr_mode;
    logic               out_ready;
    logic [W-1:0]       mux_op;
    logic               op_valid;
    logic [1:0]         op_idx;

    int n_checks = 0;
    int n_fail   = 0;

    // reference model state
    int m_op  = 0;
    int m_v   = 0;
    int m_idx = 0;
    int m_ptr = 0;

    mux_arb #(.N(N), .W(W)) dut (
        .clock     (clock),
        .reset     (reset),
        .ip        (ip),
        .sel       (sel),
        .rr_mode   (rr_mode),
        .out_ready (out_ready),
        .mux_op    (mux_op),
        .op_valid  (op_valid),
        .op_idx    (op_idx)
    );

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    typedef struct {
        logic [2:0]  sel;
        logic        rr;
        logic        rdy;
        logic [11:0] ip;
        logic [3:0]  exp_op;
        logic        exp_v;
        logic [1:0]  exp_idx;
        logic [1:0]  exp_ptr;
    } vec_t;

    vec_t vecs[$];

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // First requesting channel scanning upward from the start point, mod N.
    function automatic int winner(input logic [2:0] s, input logic rr, input int ptr);
        int start;
        start = rr ? ptr : 0;
        for (int k = 0; k < N; k++) begin
            if (s[(start + k) % N]) return (start + k) % N;
        end
        return -1;
    endfunction

    // Advance the model with the inputs present before the edge, then clock.
    task automatic cycle();
        int w;
        if (m_v == 0 || out_ready) begin
            w = winner(sel, rr_mode, m_ptr);
            if (w >= 0) begin
                m_op  = int'(ip[w]);
                m_idx = w;
                m_v   = 1;
                if (rr_mode) m_ptr = (w + 1) % N;
            end else begin
                m_v = 0;
            end
        end
        @(posedge clock);
        #1;
    endtask

    task automatic model_reset();
        m_op = 0; m_v = 0; m_idx = 0; m_ptr = 0;
    endtask

    task automatic check_model(input string tag);
        check({tag, " op"},  int'(mux_op),     m_op);
        check({tag, " v"},   int'(op_valid),   m_v);
        check({tag, " idx"}, int'(op_idx),     m_idx);
        check({tag, " ptr"}, int'(dut.rr_ptr), m_ptr);
    endtask

    initial begin
        reset = 1'b1; ip = '0; sel = '0; rr_mode = 1'b0; out_ready = 1'b0;
        model_reset();
        #3;
        check("rst op",  int'(mux_op),   0);
        check("rst v",   int'(op_valid), 0);
        check("rst idx", int'(op_idx),   0);
        check("rst ptr", int'(dut.rr_ptr), 0);
        #9 reset = 1'b0;  // mid-cycle release (edges at 5,15,...)

        // fixed priority
        vecs.push_back('{3'b111, 1'b0, 1'b1, 12'h35A, 4'hA, 1'b1, 2'd0, 2'd0});
        vecs.push_back('{3'b110, 1'b0, 1'b1, 12'h35A, 4'h5, 1'b1, 2'd1, 2'd0});
        vecs.push_back('{3'b100, 1'b0, 1'b1, 12'h35A, 4'h3, 1'b1, 2'd2, 2'd0});
        vecs.push_back('{3'b000, 1'b0, 1'b1, 12'h35A, 4'h3, 1'b0, 2'd2, 2'd0});
        // round-robin rotation
        vecs.push_back('{3'b111, 1'b1, 1'b1, 12'h35A, 4'hA, 1'b1, 2'd0, 2'd1});
        vecs.push_back('{3'b111, 1'b1, 1'b1, 12'h35A, 4'h5, 1'b1, 2'd1, 2'd2});
        vecs.push_back('{3'b111, 1'b1, 1'b1, 12'h35A, 4'h3, 1'b1, 2'd2, 2'd0});
        vecs.push_back('{3'b111, 1'b1, 1'b1, 12'h35A, 4'hA, 1'b1, 2'd0, 2'd1});
        // wrap from ptr 2
        vecs.push_back('{3'b010, 1'b1, 1'b1, 12'h35A, 4'h5, 1'b1, 2'd1, 2'd2});
        vecs.push_back('{3'b001, 1'b1, 1'b1, 12'h35A, 4'hA, 1'b1, 2'd0, 2'd1});
        vecs.push_back('{3'b101, 1'b1, 1'b1, 12'h35A, 4'h3, 1'b1, 2'd2, 2'd0});
        // stall with changing inputs, then release
        vecs.push_back('{3'b010, 1'b1, 1'b1, 12'h35A, 4'h5, 1'b1, 2'd1, 2'd2});
        vecs.push_back('{3'b100, 1'b1, 1'b0, 12'h789, 4'h5, 1'b1, 2'd1, 2'd2});
        vecs.push_back('{3'b001, 1'b1, 1'b0, 12'hEDC, 4'h5, 1'b1, 2'd1, 2'd2});
        vecs.push_back('{3'b100, 1'b0, 1'b0, 12'h789, 4'h5, 1'b1, 2'd1, 2'd2});
        vecs.push_back('{3'b100, 1'b1, 1'b1, 12'h789, 4'h7, 1'b1, 2'd2, 2'd0});
        // empty accept, then output holds
        vecs.push_back('{3'b000, 1'b1, 1'b1, 12'h789, 4'h7, 1'b0, 2'd2, 2'd0});

        for (int i = 0; i < vecs.size(); i++) begin
            sel       = vecs[i].sel;
            rr_mode   = vecs[i].rr;
            out_ready = vecs[i].rdy;
            ip        = vecs[i].ip;
            cycle();
            check($sformatf("row%0d op", i),  int'(mux_op),     int'(vecs[i].exp_op));
            check($sformatf("row%0d v", i),   int'(op_valid),   int'(vecs[i].exp_v));
            check($sformatf("row%0d idx", i), int'(op_idx),     int'(vecs[i].exp_idx));
            check($sformatf("row%0d ptr", i), int'(dut.rr_ptr), int'(vecs[i].exp_ptr));
        end

        // reset mid-stream: load A, move ptr, then assert reset between edges
        sel = 3'b111; rr_mode = 1'b1; out_ready = 1'b1; ip = 12'h35A;
        cycle();
        check("pre-rst op", int'(mux_op), 4'hA);
        check("pre-rst v",  int'(op_valid), 1);
        out_ready = 1'b0;
        #3 reset = 1'b1;
        model_reset();
        #1;
        check("async rst op",  int'(mux_op),     0);
        check("async rst v",   int'(op_valid),   0);
        check("async rst idx", int'(op_idx),     0);
        check("async rst ptr", int'(dut.rr_ptr), 0);
        @(posedge clock);
        #4 reset = 1'b0;
        sel = 3'b010; rr_mode = 1'b0; out_ready = 1'b1;
        cycle();
        check("post-rst op",  int'(mux_op),   4'h5);
        check("post-rst idx", int'(op_idx),   1);
        check("post-rst v",   int'(op_valid), 1);

        // randomized traffic against the model
        for (int c = 0; c < 400; c++) begin
            ip        = 12'($urandom);
            sel       = ($urandom_range(0, 4) == 0) ? 3'b000 : 3'($urandom);
            out_ready = ($urandom_range(0, 3) != 0);
            if ($urandom_range(0, 9) == 0) rr_mode = ~rr_mode;
            cycle();
            check_model($sformatf("rand%0d", c));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/mux_arb.md
Name: mux_arb

Overview:
Parametrised N-channel registered data selector, successor to the 3-input registered priority mux. It selects one requesting channel per accepted cycle and registers that channel's data. Two run-time modes: fixed priority (lowest index wins) or round-robin. An output valid/ready handshake lets a downstream consumer stall it. It sits between multiple producers and a single-consumer datapath.

Parameters:
N, 3, number of input channels (>=1)
W, 4, data width per channel
IDXW, (N>1 ? $clog2(N) : 1), width of channel index (derived localparam, not overridable)

Ports:
clock  input  1  rising-edge clock
reset  input  1  asynchronous, active-high reset
ip  input  N*W (packed [N-1:0][W-1:0])  channel data
sel  input  N  per-channel request; sel[i]=1 means channel i requests
rr_mode  input  1  0 = fixed priority, 1 = round-robin
out_ready  input  1  consumer can take mux_op this cycle
mux_op  output  W  registered selected data
op_valid  output  1  mux_op holds a granted, unconsumed value
op_idx  output  IDXW  index of channel that produced mux_op

Behaviour:
- Reset (async assert, sync-safe deassert assumed by top level): mux_op=0, op_valid=0, op_idx=0, internal rr_ptr=0. Takes effect immediately, including mid-transfer. No state survives.
- accept = !op_valid || out_ready. Evaluated every clock edge.
- accept=1 and |sel=1: winner w is chosen, then on the edge mux_op<=ip[w], op_idx<=w, op_valid<=1. Latency is 1 cycle from sel/ip sampled to mux_op.
- accept=1 and sel==0: op_valid<=0. mux_op and op_idx hold their previous values (hold behaviour as in the predecessor).
- accept=0 (stall): mux_op, op_idx, op_valid and rr_ptr all hold. sel and ip are ignored. Requests are not queued; producers must hold sel.
- Fixed mode: w = lowest index i with sel[i]=1. This is identical to the predecessor's sel1>sel2>sel3 priority when N=3.
- Round-robin mode: w = first i with sel[i]=1, scanning ascending from rr_ptr and wrapping N-1 to 0.
- rr_ptr update: on a grant in rr_mode, rr_ptr <= (w==N-1) ? 0 : w+1. In fixed mode rr_ptr holds. No update occurs on stall or on no-request.
- A rr_mode change takes effect at the next accepted edge. rr_ptr is not reset by a mode change.
- N=1: channel 0 always wins; rr_ptr is constant 0.
- Simultaneous out_ready=1 and new request while op_valid=1: the old value is consumed and the new value is loaded on the same edge (full throughput, one transfer per cycle).

Optional Feature:
Macro MUX_ARB_SVA_EN. When defined, embedded concurrent assertions (disabled iff reset) are compiled in, each with a $error message:
- fixed-mode priority correctness: mux_op == $past(ip[lowest set sel]);
- one-cycle latency;
- stability of mux_op/op_idx/op_valid while op_valid && !out_ready;
- op_idx < N;
- op_valid falls only after accept with sel==0.
When undefined, no assertions are compiled. RTL behaviour is identical either way.

Decomposition:
- Package mux_arb_pkg: typedef enum logic {MODE_FIXED=1'b0, MODE_RR=1'b1} mux_mode_e; reset-value constant for rr_ptr/op_idx (0).
- One sub-module: mux_arb_picker. Purely combinational; inputs sel, rr_ptr, mode; outputs winner index w and any_req. It implements both the priority scan and the rotated scan.
- The top module holds the registers, handshake and assertions.

Test Plan:
1. Fixed, N=3, ip0=4'hA, ip1=4'h5, ip2=4'h3, sel=3'b111, out_ready=1 -> next cycle mux_op=4'hA, op_idx=0, op_valid=1.
2. Fixed, same ip, sel sequence 3'b110, 3'b100, 3'b000 -> mux_op 4'h5/idx1, 4'h3/idx2, then op_valid=0 with mux_op=4'h3 held.
3. Round-robin, sel=3'b111 held 4 cycles, out_ready=1 -> op_idx 0,1,2,0; rr_ptr 1,2,0,1.
4. Round-robin, rr_ptr=2, sel=3'b001 -> op_idx=0, rr_ptr=1. Then sel=3'b101 -> op_idx=2, rr_ptr=0.
5. Stall: op_valid=1, mux_op=4'h5, op_idx=1. Drop out_ready for 3 cycles while ip and sel change -> outputs and rr_ptr unchanged. Raise out_ready -> next winner loaded on that edge.
6. Reset mid-stream: assert reset between edges while op_valid=1, mux_op=4'hA -> outputs 0/0/0 immediately. After release, sel=3'b010 -> mux_op=ip1, op_idx=1.
